// File: rtl/qwi_reg_bank.sv
// qwi_reg_bank: parameterised register bank behind a BRAM-style PS master port.
// Each slot is RW, RO, W1C or PULSE; reads are registered with one cycle of latency.
module qwi_reg_bank #(
    parameter int unsigned              REGCNT  = 4,
    parameter int unsigned              AWID    = 9,
    parameter int unsigned              DWID    = 32,
    parameter logic [2*REGCNT-1:0]      MODE    = '0,
    parameter logic [REGCNT*DWID-1:0]   RST_VAL = '0
) (
    input  logic                     reg_clk,
    input  logic                     sys_rst,
    input  logic                     reg_ce,
    input  logic                     reg_rst,
    input  logic [DWID/8-1:0]        reg_we,
    input  logic [AWID-1:0]          reg_addr,
    input  logic [DWID-1:0]          reg_wrd,
    output logic [DWID-1:0]          reg_rdd,
    output logic [REGCNT*DWID-1:0]   reg_out,
    input  logic [REGCNT*DWID-1:0]   reg_in,
    input  logic [REGCNT*DWID-1:0]   reg_evt,
    output logic                     irq
);

    typedef enum logic [1:0] {
        REG_RW    = 2'd0,
        REG_RO    = 2'd1,
        REG_W1C   = 2'd2,
        REG_PULSE = 2'd3
    } reg_mode_e;

    localparam int unsigned NBYTE = DWID / 8;

    logic            wr_en;
    logic            rd_en;
    logic [DWID-1:0] wmask;

    assign wr_en = reg_ce && (reg_we != '0);
    assign rd_en = reg_ce && (reg_we == '0);

    always_comb begin
        wmask = '0;
        for (int unsigned b = 0; b < NBYTE; b++) begin
            wmask[8*b +: 8] = {8{reg_we[b]}};
        end
    end

    logic [DWID-1:0]   rd_val [REGCNT];
    logic [REGCNT-1:0] w1c_any;

    for (genvar g = 0; g < REGCNT; g++) begin : g_reg
        localparam reg_mode_e       M  = reg_mode_e'(MODE[2*g +: 2]);
        localparam logic [DWID-1:0] RV = RST_VAL[DWID*g +: DWID];

        logic            hit;
        logic [DWID-1:0] val_q;
        logic [DWID-1:0] val_d;

        assign hit = wr_en && (reg_addr == AWID'(g));

        // W1C: clear from the write is applied first so a same-cycle event wins.
        always_comb begin
            val_d = val_q;
            case (M)
                REG_RW:    if (hit) val_d = (val_q & ~wmask) | (reg_wrd & wmask);
                REG_W1C:   val_d = (hit ? (val_q & ~(reg_wrd & wmask)) : val_q)
                                   | reg_evt[DWID*g +: DWID];
                REG_PULSE: val_d = hit ? (reg_wrd & wmask) : '0;
                default:   val_d = '0;
            endcase
        end

        always_ff @(posedge reg_clk) begin
            if (sys_rst) begin
                val_q <= (M == REG_RW || M == REG_W1C) ? RV : '0;
            end else begin
                val_q <= val_d;
            end
        end

        assign reg_out[DWID*g +: DWID] = val_q;
        assign rd_val[g]  = (M == REG_RO)    ? reg_in[DWID*g +: DWID] :
                            (M == REG_PULSE) ? '0 : val_q;
        assign w1c_any[g] = (M == REG_W1C) && (val_q != '0);
    end

    // Full-width compare per slot, so out-of-range addresses never alias.
    logic [DWID-1:0] rd_sel;

    always_comb begin
        rd_sel = '0;
        for (int unsigned i = 0; i < REGCNT; i++) begin
            if (reg_addr == AWID'(i)) rd_sel = rd_val[i];
        end
    end

    logic [DWID-1:0] rdd_q;
    logic            irq_q;

    always_ff @(posedge reg_clk) begin
        if (sys_rst) begin
            rdd_q <= '0;
            irq_q <= 1'b0;
        end else begin
            if (reg_rst) begin
                rdd_q <= '0;
            end else if (rd_en) begin
                rdd_q <= rd_sel;
            end
            irq_q <= |w1c_any;
        end
    end

    assign reg_rdd = rdd_q;
    assign irq     = irq_q;

    // Fabric inputs are only consumed by slots of the matching mode.
    logic unused_fabric;
    assign unused_fabric = ^{reg_in, reg_evt};

endmodule

// File: tb/tb_qwi_reg_bank.sv
// Bench for qwi_reg_bank: directed vector table, hand sequences, and a
// randomized phase checked against a register-level behavioural model.
module tb_qwi_reg_bank;

    localparam int unsigned REGCNT = 4;
    localparam int unsigned AWID   = 9;
    localparam int unsigned DWID   = 32;
    // slot0 RO, slot1 RW, slot2 W1C, slot3 PULSE
    localparam logic [2*REGCNT-1:0]    MODE    = 8'hE1;
    localparam logic [REGCNT*DWID-1:0] RST_VAL = {32'hFFFF_FFFF, 32'h0000_0000,
                                                  32'h0000_000F, 32'h5555_5555};

    logic                   clk = 1'b0;
    logic                   sys_rst, reg_ce, reg_rst;
    logic [3:0]             reg_we;
    logic [AWID-1:0]        reg_addr;
    logic [DWID-1:0]        reg_wrd, reg_rdd;
    logic [REGCNT*DWID-1:0] reg_out, reg_in, reg_evt;
    logic                   irq;

    qwi_reg_bank #(
        .REGCNT (REGCNT),
        .AWID   (AWID),
        .DWID   (DWID),
        .MODE   (MODE),
        .RST_VAL(RST_VAL)
    ) dut (
        .reg_clk (clk),
        .sys_rst (sys_rst),
        .reg_ce  (reg_ce),
        .reg_rst (reg_rst),
        .reg_we  (reg_we),
        .reg_addr(reg_addr),
        .reg_wrd (reg_wrd),
        .reg_rdd (reg_rdd),
        .reg_out (reg_out),
        .reg_in  (reg_in),
        .reg_evt (reg_evt),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic r, input logic c, input logic [3:0] w,
                         input logic [8:0] a, input logic [31:0] d, input logic [31:0] e2);
        sys_rst  = s;
        reg_rst  = r;
        reg_ce   = c;
        reg_we   = w;
        reg_addr = a;
        reg_wrd  = d;
        reg_evt  = {32'hFFFF_FFFF, e2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        reg_in   = {{3{32'hDEAD_BEEF}}, 32'h0103_2020};
    endtask

    task automatic chk_all(input string tag, input logic [31:0] rdd, input logic [31:0] o1,
                           input logic [31:0] o2, input logic [31:0] o3, input logic ir);
        chk({tag, "_rdd"}, reg_rdd, rdd);
        chk({tag, "_out0"}, reg_out[31:0], 32'h0);
        chk({tag, "_out1"}, reg_out[63:32], o1);
        chk({tag, "_out2"}, reg_out[95:64], o2);
        chk({tag, "_out3"}, reg_out[127:96], o3);
        chk({tag, "_irq"}, {31'b0, irq}, {31'b0, ir});
    endtask

    typedef struct {
        logic        sys, rrst, ce;
        logic [3:0]  we;
        logic [8:0]  addr;
        logic [31:0] wrd, evt2;
        logic [31:0] e_rdd, e_o1, e_o2, e_o3;
        logic        e_irq;
    } vec_t;

    function automatic vec_t mk(logic sys, logic rrst, logic ce, logic [3:0] we, logic [8:0] addr,
                                logic [31:0] wrd, logic [31:0] evt2, logic [31:0] e_rdd,
                                logic [31:0] e_o1, logic [31:0] e_o2, logic [31:0] e_o3,
                                logic e_irq);
        vec_t v;
        v.sys = sys; v.rrst = rrst; v.ce = ce; v.we = we; v.addr = addr;
        v.wrd = wrd; v.evt2 = evt2; v.e_rdd = e_rdd; v.e_o1 = e_o1;
        v.e_o2 = e_o2; v.e_o3 = e_o3; v.e_irq = e_irq;
        return v;
    endfunction

    // Behavioural model: slot contents as the fabric sees them.
    typedef enum int {M_RW, M_RO, M_W1C, M_PULSE} tb_mode_e;
    logic [31:0] mdl_val [REGCNT];
    logic [31:0] mdl_rdd;
    logic        mdl_irq;

    function automatic tb_mode_e mode_of(int r);
        case (r)
            0:       return M_RO;
            1:       return M_RW;
            2:       return M_W1C;
            default: return M_PULSE;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] nxt [REGCNT];
        logic        any_w1c;
        any_w1c = 1'b0;
        for (int r = 0; r < REGCNT; r++)
            if (mode_of(r) == M_W1C && mdl_val[r] != 32'h0) any_w1c = 1'b1;
        if (sys_rst) begin
            for (int r = 0; r < REGCNT; r++)
                nxt[r] = (mode_of(r) == M_RW || mode_of(r) == M_W1C) ? RST_VAL[32*r +: 32] : 32'h0;
            mdl_rdd = 32'h0;
            mdl_irq = 1'b0;
        end else begin
            for (int r = 0; r < REGCNT; r++)
                nxt[r] = (mode_of(r) == M_RW || mode_of(r) == M_W1C) ? mdl_val[r] : 32'h0;
            if (reg_ce && reg_we != 4'h0 && reg_addr < REGCNT) begin
                for (int b = 0; b < 4; b++) begin
                    if (reg_we[b]) begin
                        case (mode_of(int'(reg_addr)))
                            M_RW, M_PULSE: nxt[reg_addr][8*b +: 8] = reg_wrd[8*b +: 8];
                            M_W1C: nxt[reg_addr][8*b +: 8] = nxt[reg_addr][8*b +: 8] & ~reg_wrd[8*b +: 8];
                            default: ;
                        endcase
                    end
                end
            end
            for (int r = 0; r < REGCNT; r++)
                if (mode_of(r) == M_W1C) nxt[r] = nxt[r] | reg_evt[32*r +: 32];
            if (reg_rst) begin
                mdl_rdd = 32'h0;
            end else if (reg_ce && reg_we == 4'h0) begin
                if (reg_addr >= REGCNT)                     mdl_rdd = 32'h0;
                else if (mode_of(int'(reg_addr)) == M_RO)    mdl_rdd = reg_in[32*reg_addr +: 32];
                else if (mode_of(int'(reg_addr)) == M_PULSE) mdl_rdd = 32'h0;
                else                                        mdl_rdd = mdl_val[reg_addr];
            end
            mdl_irq = any_w1c;
        end
        for (int r = 0; r < REGCNT; r++) mdl_val[r] = nxt[r];
    endtask

    vec_t vt[$];

    initial begin
        // Reset held three cycles with a write and event attempted throughout.
        drive(1, 0, 1, 4'hF, 9'd1, 32'hFFFF_0000, 32'h0000_00FF);
        repeat (3) cycle();
        chk_all("reset3", 32'h0, 32'h0000_000F, 32'h0, 32'h0, 1'b0);

        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h0,         32'h0000_000F,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,1,4'h5,9'd1,  32'hA5A5_5A5A, 32'h0,  32'h0,         32'h00A5_005A,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,1,4'h0,9'd1,  32'h0,         32'h0,  32'h00A5_005A, 32'h00A5_005A,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,1,4'hF,9'd0,  32'hFFFF_FFFF, 32'h0,  32'h00A5_005A, 32'h00A5_005A,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,1,4'h0,9'd0,  32'h0,         32'h0,  32'h0103_2020, 32'h00A5_005A,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h8,  32'h0103_2020, 32'h00A5_005A,32'h8, 32'h0,1'b0));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h0103_2020, 32'h00A5_005A,32'h8, 32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'hF,9'd2,  32'h8,         32'h8,  32'h0103_2020, 32'h00A5_005A,32'h8, 32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'hF,9'd2,  32'h8,         32'h0,  32'h0103_2020, 32'h00A5_005A,32'h0, 32'h0,1'b1));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h0103_2020, 32'h00A5_005A,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h30, 32'h0103_2020, 32'h00A5_005A,32'h30,32'h0,1'b0));
        vt.push_back(mk(0,0,1,4'hF,9'd2,  32'h0,         32'h0,  32'h0103_2020, 32'h00A5_005A,32'h30,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h2,9'd2,  32'hFFFF_FFFF, 32'h0,  32'h0103_2020, 32'h00A5_005A,32'h30,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd2,  32'h0,         32'h1,  32'h30,        32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h1,9'd3,  32'h1,         32'h0,  32'h30,        32'h00A5_005A,32'h31,32'h1,1'b1));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h30,        32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd3,  32'h0,         32'h0,  32'h0,         32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd1,  32'h0,         32'h0,  32'h00A5_005A, 32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd7,  32'h0,         32'h0,  32'h0,         32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'hF,9'd7,  32'hFFFF_FFFF, 32'h0,  32'h0,         32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'hF,9'h105,32'h0,         32'h0,  32'h0,         32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd1,  32'h0,         32'h0,  32'h00A5_005A, 32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd4,  32'h0,         32'h0,  32'h0,         32'h00A5_005A,32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'hF,9'd1,  32'h1234,      32'h0,  32'h0,         32'h1234,     32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h0,9'd1,  32'h0,         32'h0,  32'h1234,      32'h1234,     32'h31,32'h0,1'b1));
        vt.push_back(mk(0,1,1,4'h0,9'd1,  32'h0,         32'h0,  32'h0,         32'h1234,     32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h0,         32'h1234,     32'h31,32'h0,1'b1));
        vt.push_back(mk(0,0,1,4'h1,9'd3,  32'h1,         32'h0,  32'h0,         32'h1234,     32'h31,32'h1,1'b1));
        vt.push_back(mk(1,0,1,4'hF,9'd1,  32'hFFFF_FFFF, 32'hFF, 32'h0,         32'h0000_000F,32'h0, 32'h0,1'b0));
        vt.push_back(mk(0,0,0,4'h0,9'd0,  32'h0,         32'h0,  32'h0,         32'h0000_000F,32'h0, 32'h0,1'b0));

        foreach (vt[i]) begin
            drive(vt[i].sys, vt[i].rrst, vt[i].ce, vt[i].we, vt[i].addr, vt[i].wrd, vt[i].evt2);
            cycle();
            chk_all($sformatf("row%0d", i), vt[i].e_rdd, vt[i].e_o1, vt[i].e_o2, vt[i].e_o3, vt[i].e_irq);
        end

        // Back-to-back PULSE writes: each value lasts one cycle, then zero.
        drive(0, 0, 1, 4'h1, 9'd3, 32'h1, 32'h0);
        cycle();
        chk("pulse_a", reg_out[127:96], 32'h1);
        drive(0, 0, 1, 4'h1, 9'd3, 32'h2, 32'h0);
        cycle();
        chk("pulse_b", reg_out[127:96], 32'h2);
        drive(0, 0, 0, 4'h0, 9'd0, 32'h0, 32'h0);
        cycle();
        chk("pulse_end", reg_out[127:96], 32'h0);

        // Randomized phase against the behavioural model.
        for (int r = 0; r < REGCNT; r++) mdl_val[r] = 32'h0;
        mdl_rdd = 32'h0;
        mdl_irq = 1'b0;
        for (int n = 0; n < 500; n++) begin
            sys_rst  = (n == 0) || ($urandom_range(0, 39) == 0);
            reg_rst  = ($urandom_range(0, 15) == 0);
            reg_ce   = 1'($urandom_range(0, 1));
            reg_we   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            reg_addr = ($urandom_range(0, 7) == 0) ? 9'($urandom) : 9'($urandom_range(0, 4));
            reg_wrd  = $urandom;
            reg_in   = {$urandom, $urandom, $urandom, $urandom};
            for (int s = 0; s < REGCNT; s++)
                reg_evt[32*s +: 32] = ($urandom_range(0, 3) == 0) ? ($urandom & $urandom & $urandom) : 32'h0;
            model_edge();
            cycle();
            for (int r = 0; r < REGCNT; r++)
                chk($sformatf("rnd%0d_out%0d", n, r), reg_out[32*r +: 32], mdl_val[r]);
            chk($sformatf("rnd%0d_rdd", n), reg_rdd, mdl_rdd);
            chk($sformatf("rnd%0d_irq", n), {31'b0, irq}, {31'b0, mdl_irq});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
